// File: rtl/rapid_pkg.sv
// rtl/rapid_pkg.sv - RV32I encode classes, opcodes, NOP and encode/range helpers
package rapid_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    CLS_UPPER   = 3'd0,
    CLS_JAL     = 3'd1,
    CLS_JALR    = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_LOAD    = 3'd4,
    CLS_STORE   = 3'd5,
    CLS_ALU_IMM = 3'd6,
    CLS_ALU_REG = 3'd7
  } enc_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wr_state_e;

  // Opcodes shared with decoder_logic so both directions agree on one table
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_ALU_REG = 7'b0110011;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    enc_class_e      cls;
    logic            auipc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            iop;
    logic [XLEN-1:0] imm;
  } enc_fields_t;

  // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shamt instead of an immediate
  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

  function automatic logic [XLEN-1:0] encode_instr(input enc_fields_t f);
    logic [XLEN-1:0] w;
    case (f.cls)
      CLS_UPPER:   w = {f.imm[31:12], f.rd, (f.auipc ? OP_AUIPC : OP_LUI)};
      CLS_JAL:     w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, OP_JAL};
      CLS_JALR:    w = {f.imm[11:0], f.rs1, 3'b000, f.rd, OP_JALR};
      CLS_BRANCH:  w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                        f.imm[4:1], f.imm[11], OP_BRANCH};
      CLS_LOAD:    w = {f.imm[11:0], f.rs1, f.funct3, f.rd, OP_LOAD};
      CLS_STORE:   w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], OP_STORE};
      CLS_ALU_IMM: w = is_shift(f.funct3)
                     ? {1'b0, (f.iop && (f.funct3 == 3'b101)), 5'b00000, f.imm[4:0],
                        f.rs1, f.funct3, f.rd, OP_ALU_IMM}
                     : {f.imm[11:0], f.rs1, f.funct3, f.rd, OP_ALU_IMM};
      CLS_ALU_REG: w = {1'b0, f.iop, 5'b00000, f.rs2, f.rs1, f.funct3, f.rd, OP_ALU_REG};
      default:     w = NOP;
    endcase
    return w;
  endfunction

  // True when imm sign-extends cleanly from its low 'width' bits
  function automatic logic fits_signed(input logic [XLEN-1:0] imm, input int unsigned width);
    logic [XLEN-1:0] hi;
    hi = XLEN'($signed(imm) >>> (width - 1));
    return (hi == '0) || (hi == '1);
  endfunction

  function automatic logic imm_fits(input enc_fields_t f);
    logic ok;
    case (f.cls)
      CLS_UPPER:   ok = (f.imm[11:0] == 12'h000);
      CLS_JAL:     ok = fits_signed(f.imm, 21) && !f.imm[0];
      CLS_BRANCH:  ok = fits_signed(f.imm, 13) && !f.imm[0];
      CLS_ALU_IMM: ok = is_shift(f.funct3) ? (f.imm[XLEN-1:5] == '0) : fits_signed(f.imm, 12);
      CLS_ALU_REG: ok = 1'b1;
      default:     ok = fits_signed(f.imm, 12);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_writer_if.sv
// rtl/instr_encoder_writer_if.sv - field-bundle handshake and instruction-memory write bus
interface instr_encoder_writer_if;
  import rapid_pkg::*;

  logic            valid;
  logic            ready;
  enc_class_e      cls;
  logic            auipc;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic            iop;
  logic [XLEN-1:0] imm;

  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;

  modport master (
    output valid, cls, auipc, rd, rs1, rs2, funct3, iop, imm, mem_ready,
    input  ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  valid, cls, auipc, rd, rs1, rs2, funct3, iop, imm, mem_ready,
    output ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO holding encoded words ahead of memory writes
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/instr_encoder_writer.sv
// rtl/instr_encoder_writer.sv - encode RV32I fields and stream words to instruction memory; option ENCODER_RANGE_CHECK_EN
module instr_encoder_writer
  import rapid_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [XLEN-1:0]        i_base_addr,
  input  logic                   i_stop,
  instr_encoder_writer_if.slave  bus,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_imm_err
);
  wr_state_e       r_state;
  logic [XLEN-1:0] r_addr;
  logic [CNT_W-1:0] r_count;
  logic            r_done;
  enc_fields_t     w_fields;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_write;

  // Gather the incoming bundle into one struct for the encoder
  always_comb begin
    w_fields        = '0;
    w_fields.cls    = bus.cls;
    w_fields.auipc  = bus.auipc;
    w_fields.rd     = bus.rd;
    w_fields.rs1    = bus.rs1;
    w_fields.rs2    = bus.rs2;
    w_fields.funct3 = bus.funct3;
    w_fields.iop    = bus.iop;
    w_fields.imm    = bus.imm;
  end

  // Ready depends only on registered state so a same-cycle pop never opens a full FIFO
  assign bus.ready = (r_state == ST_RUN) && !w_full;
  assign w_accept  = bus.valid && bus.ready;
  assign w_write   = !w_empty && bus.mem_ready;

`ifdef ENCODER_RANGE_CHECK_EN
  logic w_imm_ok;
  logic r_imm_err;

  assign w_imm_ok  = imm_fits(w_fields);
  assign w_word    = w_imm_ok ? encode_instr(w_fields) : NOP;
  assign o_imm_err = r_imm_err;

  // Sticky range error, cleared only by the start that opens a new run
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                              r_imm_err <= 1'b0;
    else if ((r_state == ST_IDLE) && i_start)  r_imm_err <= 1'b0;
    else if (w_accept && !w_imm_ok)            r_imm_err <= 1'b1;
  end
`else
  assign w_word    = encode_instr(w_fields);
  assign o_imm_err = 1'b0;
`endif

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_accept),
    .i_wdata (w_word),
    .i_pop   (w_write),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Run control, write address and written-word counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_write) begin
        r_addr  <= r_addr + XLEN'(4);
        r_count <= r_count + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_addr  <= i_base_addr & ~XLEN'(3);
            r_count <= '0;
          end
        end
        ST_RUN: begin
          if (i_stop) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_we    = !w_empty;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = w_head;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = r_done;
  assign o_count       = r_count;
endmodule

// File: tb/tb_instr_encoder_writer.sv
// tb/tb_instr_encoder_writer.sv - randomized self-checking bench for instr_encoder_writer
module tb_instr_encoder_writer;
  import rapid_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] base = 32'h0;
  logic        busy, done, imm_err;
  logic [15:0] count;

  instr_encoder_writer_if bus();

  instr_encoder_writer #(.DEPTH(4), .CNT_W(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_base_addr (base),
    .i_stop      (stop),
    .bus         (bus),
    .o_busy      (busy),
    .o_done      (done),
    .o_count     (count),
    .o_imm_err   (imm_err)
  );

  always #5 clk = ~clk;

`ifdef ENCODER_RANGE_CHECK_EN
  localparam logic [31:0] BIG_IMM_WORD = 32'h0000_0013;
  localparam logic [31:0] BIG_IMM_ERR  = 32'd1;
`else
  localparam logic [31:0] BIG_IMM_WORD = 32'h0000_0093;
  localparam logic [31:0] BIG_IMM_ERR  = 32'd0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_addr = 32'h0;
  int          m_count = 0;
  bit          m_err = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] x, input int hi, input int lo);
    return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic logic [31:0] ref_encode(input enc_class_e c, input logic auipc,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic iop, input logic [31:0] imm, output bit bad);
    logic [31:0] w;
    int s;
    logic [31:0] rdv, rs1v, rs2v, f3v;
    s    = $signed(imm);
    rdv  = 32'(rd) << 7;
    rs1v = 32'(rs1) << 15;
    rs2v = 32'(rs2) << 20;
    f3v  = 32'(f3) << 12;
    bad  = 1'b0;
    case (c)
      CLS_UPPER: begin
        w = (imm & 32'hFFFF_F000) | rdv | (auipc ? 32'h17 : 32'h37);
        bad = (imm & 32'hFFF) != 0;
      end
      CLS_JAL: begin
        w = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
          | (fld(imm, 19, 12) << 12) | rdv | 32'h6F;
        bad = (s < -(1 << 20)) || (s >= (1 << 20)) || imm[0];
      end
      CLS_JALR: begin
        w = (fld(imm, 11, 0) << 20) | rs1v | rdv | 32'h67;
        bad = (s < -2048) || (s > 2047);
      end
      CLS_BRANCH: begin
        w = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | rs2v | rs1v | f3v
          | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 32'h63;
        bad = (s < -4096) || (s > 4095) || imm[0];
      end
      CLS_LOAD: begin
        w = (fld(imm, 11, 0) << 20) | rs1v | f3v | rdv | 32'h03;
        bad = (s < -2048) || (s > 2047);
      end
      CLS_STORE: begin
        w = (fld(imm, 11, 5) << 25) | rs2v | rs1v | f3v | (fld(imm, 4, 0) << 7) | 32'h23;
        bad = (s < -2048) || (s > 2047);
      end
      CLS_ALU_IMM: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          w = ((iop && f3 == 3'd5) ? 32'h4000_0000 : 32'h0) | (fld(imm, 4, 0) << 20)
            | rs1v | f3v | rdv | 32'h13;
          bad = imm > 32'd31;
        end else begin
          w = (fld(imm, 11, 0) << 20) | rs1v | f3v | rdv | 32'h13;
          bad = (s < -2048) || (s > 2047);
        end
      end
      default: w = (iop ? 32'h4000_0000 : 32'h0) | rs2v | rs1v | f3v | rdv | 32'h33;
    endcase
`ifdef ENCODER_RANGE_CHECK_EN
    if (bad) w = 32'h0000_0013;
`else
    bad = 1'b0;
`endif
    return w;
  endfunction

  // Scoreboard: record accepted bundles, check every completed write and stall stability
  always @(negedge clk) begin : monitor
    logic [31:0] w, e;
    bit bad;
    if (rst_n) begin
      if (bus.valid && bus.ready) begin
        w = ref_encode(bus.cls, bus.auipc, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.iop, bus.imm, bad);
        exp_q.push_back(w);
        if (bad) m_err = 1'b1;
      end
      if (prev_stall) begin
        check("stall_addr", bus.mem_addr, prev_addr);
        check("stall_data", bus.mem_wdata, prev_data);
      end
      prev_stall = bus.mem_we && !bus.mem_ready;
      prev_addr  = bus.mem_addr;
      prev_data  = bus.mem_wdata;
      if (bus.mem_we && bus.mem_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check("wdata", bus.mem_wdata, e);
        check("waddr", bus.mem_addr, m_addr);
        check("count_at_write", 32'(count), 32'(m_count & 16'hFFFF));
        m_addr  = m_addr + 32'd4;
        m_count = m_count + 1;
      end
    end
  end

  task automatic idle_fields();
    bus.valid = 1'b0; bus.cls = CLS_ALU_IMM; bus.auipc = 1'b0; bus.rd = '0; bus.rs1 = '0;
    bus.rs2 = '0; bus.funct3 = '0; bus.iop = 1'b0; bus.imm = '0;
  endtask

  task automatic do_start(input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; base = b;
    @(posedge clk); #1;
    start = 1'b0;
    m_addr = b & ~32'd3; m_count = 0; m_err = 1'b0;
  endtask

  task automatic send(input enc_class_e c, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic iop, input logic [31:0] imm);
    int cyc = 0;
    @(posedge clk); #1;
    bus.valid = 1'b1; bus.cls = c; bus.auipc = 1'b0; bus.rd = rd; bus.rs1 = rs1;
    bus.rs2 = rs2; bus.funct3 = f3; bus.iop = iop; bus.imm = imm;
    forever begin
      @(negedge clk);
      if (bus.ready || cyc >= 200) break;
      cyc++;
    end
    if (!bus.ready) check("send_ready", 32'(bus.ready), 32'd1);
    @(posedge clk); #1;
    bus.valid = 1'b0;
  endtask

  task automatic do_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0; bus.valid = 1'b0;
  endtask

  task automatic wait_done();
    int pulses = 0;
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (done) pulses++;
    end while (busy && cyc < 200);
    @(negedge clk);
    if (done) pulses++;
    check("done_pulses", 32'(pulses), 32'd1);
    check("busy_after_drain", 32'(busy), 32'd0);
  endtask

  initial begin
    int acc;
    logic [31:0] r;
    idle_fields();
    bus.mem_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_imm_err", 32'(imm_err), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // first word lands one cycle after its handshake
    do_start(32'h0000_0100);
    @(negedge clk);
    check("busy_run", 32'(busy), 32'd1);
    send(CLS_ALU_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    @(negedge clk);
    check("addi_we", 32'(bus.mem_we), 32'd1);
    check("addi_word", bus.mem_wdata, 32'h0050_0093);
    check("addi_addr", bus.mem_addr, 32'h0000_0100);
    @(negedge clk);
    check("addi_count", 32'(count), 32'd1);
    send(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC);
    @(negedge clk);
    check("beq_word", bus.mem_wdata, 32'hFE20_8EE3);
    check("beq_addr", bus.mem_addr, 32'h0000_0104);
    do_stop();
    wait_done();

    // full FIFO under stall, then stop with 3 queued and a start during drain
    bus.mem_ready = 1'b0;
    do_start(32'h0000_0200);
    @(posedge clk); #1;
    bus.valid = 1'b1; bus.cls = CLS_ALU_REG; bus.rd = 5'd3; bus.rs1 = 5'd1; bus.rs2 = 5'd2;
    bus.funct3 = 3'd0; bus.iop = 1'b1; bus.imm = '0;
    acc = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ready) acc++;
      @(posedge clk); #1;
      bus.rd = 5'(3 + acc);
    end
    check("stall_accepts", 32'(acc), 32'd4);
    @(negedge clk);
    check("full_ready", 32'(bus.ready), 32'd0);
    check("add_word", bus.mem_wdata, 32'h4020_81B3);
    check("add_addr", bus.mem_addr, 32'h0000_0200);
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    do_stop();
    start = 1'b1; base = 32'h0000_0900;
    @(negedge clk);
    check("drain_ready", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.mem_ready = 1'b1;
    wait_done();
    check("drain_count", 32'(count), 32'd4);

    // address wrap; low base bits are ignored
    do_start(32'hFFFF_FFFE);
    send(CLS_LOAD, 5'd5, 5'd6, 5'd0, 3'd2, 1'b0, 32'hFFFF_FFF0);
    @(negedge clk);
    check("wrap_addr0", bus.mem_addr, 32'hFFFF_FFFC);
    send(CLS_UPPER, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000);
    @(negedge clk);
    check("wrap_addr1", bus.mem_addr, 32'h0000_0000);
    check("lui_word", bus.mem_wdata, 32'h1234_53B7);
    do_stop();
    wait_done();

    // asynchronous reset in the middle of a drain
    bus.mem_ready = 1'b0;
    do_start(32'h0000_0300);
    send(CLS_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_0800);
    send(CLS_STORE, 5'd0, 5'd2, 5'd3, 3'd2, 1'b0, 32'h0000_0014);
    send(CLS_JALR, 5'd1, 5'd4, 5'd0, 3'd0, 1'b0, 32'h0000_0008);
    do_stop();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete(); prev_stall = 1'b0;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_mem_we", 32'(bus.mem_we), 32'd0);
    check("arst_addr", bus.mem_addr, 32'd0);
    check("arst_wdata", bus.mem_wdata, 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_ready", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; bus.mem_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("post_rst_mem_we", 32'(bus.mem_we), 32'd0);

    // out-of-range immediate
    do_start(32'h0000_0400);
    send(CLS_ALU_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096);
    @(negedge clk);
    check("big_imm_word", bus.mem_wdata, BIG_IMM_WORD);
    check("big_imm_err", 32'(imm_err), BIG_IMM_ERR);
    do_stop();
    wait_done();
    check("imm_err_held", 32'(imm_err), BIG_IMM_ERR);
    do_start(32'h0000_0500);
    @(negedge clk);
    check("imm_err_cleared", 32'(imm_err), 32'd0);

    // randomized traffic against the scoreboard
    repeat (400) begin
      @(posedge clk); #1;
      bus.valid  = ($urandom_range(0, 3) != 0);
      bus.cls    = enc_class_e'(3'($urandom_range(0, 7)));
      bus.auipc  = 1'($urandom);
      bus.rd     = 5'($urandom);
      bus.rs1    = 5'($urandom);
      bus.rs2    = 5'($urandom);
      bus.funct3 = 3'($urandom);
      bus.iop    = 1'($urandom);
      r = $urandom;
      case ($urandom_range(0, 2))
        0:       bus.imm = r;
        1:       bus.imm = {{20{r[11]}}, r[11:1], 1'b0};
        default: bus.imm = 32'(r[4:0]);
      endcase
      bus.mem_ready = ($urandom_range(0, 9) < 7);
    end
    do_stop();
    bus.mem_ready = 1'b1;
    wait_done();
    check("rand_count", 32'(count), 32'(m_count & 16'hFFFF));
    check("rand_imm_err", 32'(imm_err), 32'(m_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
